// File: rtl/regfile_param.sv
// Pipelined register file: 1W/2R, post-reset init sweep, write-to-read bypass, per-register pending bits.
// Reads and busy flags are combinational; writes, sweep and scoreboard update on the rising edge.
module regfile_param #(
  parameter int                 DATA_W  = 32,
  parameter int                 ADDR_W  = 5,
  parameter int                 GP_IDX  = 28,
  parameter logic [DATA_W-1:0]  GP_INIT = DATA_W'(32'h0000_1800),
  parameter int                 SP_IDX  = 29,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(32'h0000_2ffc),
  parameter bit                 BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              ovf,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend, pend_nxt;
  logic                run;
  logic                commit;
  logic [DATA_W-1:0]   init_val;

  assign run    = (state == RUN);
  assign commit = run && we && !ovf && (waddr != '0);
  assign ready  = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    init_val = '0;
    if (cnt == ADDR_W'(GP_IDX)) init_val = GP_INIT;
    if (cnt == ADDR_W'(SP_IDX)) init_val = SP_INIT;
  end

  // Storage needs no reset branch: the sweep rewrites every entry before RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[cnt] <= init_val;
      else if (commit)   mem[waddr] <= wdata;
    end
  end

  // Clear for the retiring write first so a same-index issue overrides it.
  always_comb begin
    pend_nxt = pend;
    if (run) begin
      if (we) pend_nxt[waddr] = 1'b0;
      if (sb_set) pend_nxt[sb_addr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (run) begin
      if (raddr_a != '0) begin
        if (BYPASS && commit && (raddr_a == waddr)) rdata_a = wdata;
        else                                        rdata_a = mem[raddr_a];
      end
      if (raddr_b != '0) begin
        if (BYPASS && commit && (raddr_b == waddr)) rdata_b = wdata;
        else                                        rdata_b = mem[raddr_b];
      end
    end
  end

  assign busy_a = run && pend[raddr_a];
  assign busy_b = run && pend[raddr_b];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one forwarding and one non-forwarding instance on shared inputs.
module tb_regfile_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, we, ovf, sb_set;
  logic [ADDR_W-1:0] waddr, raddr_a, raddr_b, sb_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
  logic              busy_a, busy_b, ready, nb_busy_a, nb_busy_b, nb_ready;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .ovf(ovf), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_a(busy_a), .busy_b(busy_b), .ready(ready)
  );

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we), .ovf(ovf), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b),
    .sb_set(sb_set), .sb_addr(sb_addr), .busy_a(nb_busy_a), .busy_b(nb_busy_b), .ready(nb_ready)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; ovf = 1'b0; sb_set = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    we = 1'b1; ovf = 1'b0; waddr = a; wdata = d;
    tick();
    idle();
  endtask

  // Counts edges from rst deassertion until ready rises, bounded.
  task automatic sweep_len(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; idle(); waddr = '0; wdata = '0; raddr_a = 5'd28; raddr_b = 5'd29; sb_addr = '0;
    tick();
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_rdata_a", rdata_a, 32'd0);
    check("reset_busy", {30'd0, busy_a, busy_b}, 32'd0);
    rst = 1'b0;

    // Sweep length and init contents
    sweep_len(n);
    check("sweep_cycles", 32'(n), 32'd32);
    check("nb_ready", {31'd0, nb_ready}, 32'd1);
    #1;
    check("gp_init", rdata_a, 32'h0000_1800);
    check("sp_init", rdata_b, 32'h0000_2ffc);
    raddr_a = 5'd5;
    #1;
    check("r5_init", rdata_a, 32'd0);

    // Dirty entry 5, then reset mid-sweep; writes and sb_set during INIT must be ignored
    wr(5'd5, 32'h0000_0077);
    #1;
    check("r5_written", rdata_a, 32'h0000_0077);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_ready_low", {31'd0, ready}, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF; sb_set = 1'b1; sb_addr = 5'd5;
    #1;
    check("init_rdata_zero", rdata_a, 32'd0);
    sweep_len(n);
    idle();
    check("mid_sweep_cycles", 32'(n), 32'd32);
    #1;
    check("r5_reinit", rdata_a, 32'd0);
    check("r5_busy_ignored", {31'd0, busy_a}, 32'd0);
    raddr_a = 5'd28;
    #1;
    check("gp_reinit", rdata_a, 32'h0000_1800);

    // Write/read and zero register
    wr(5'd7, 32'hDEAD_BEEF);
    wr(5'd0, 32'h0000_1234);
    raddr_a = 5'd7; raddr_b = 5'd0;
    #1;
    check("r7_read", rdata_a, 32'hDEAD_BEEF);
    check("r0_read", rdata_b, 32'd0);

    // Overflow gating; retirement clears the pending bit anyway
    wr(5'd3, 32'd5);
    sb_set = 1'b1; sb_addr = 5'd3; tick(); idle();
    raddr_a = 5'd3;
    #1;
    check("r3_busy_set", {31'd0, busy_a}, 32'd1);
    we = 1'b1; ovf = 1'b1; waddr = 5'd3; wdata = 32'd9;
    #1;
    check("ovf_no_bypass", rdata_a, 32'd5);
    tick(); idle();
    check("r3_after_ovf", rdata_a, 32'd5);
    check("r3_busy_cleared", {31'd0, busy_a}, 32'd0);

    // Bypass vs. no bypass
    wr(5'd4, 32'h0000_0011);
    raddr_a = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'hA5A5_0001;
    #1;
    check("bypass_on", rdata_a, 32'hA5A5_0001);
    check("bypass_off", nb_rdata_a, 32'h0000_0011);
    tick(); idle();
    check("nb_after_edge", nb_rdata_a, 32'hA5A5_0001);

    // Scoreboard
    sb_set = 1'b1; sb_addr = 5'd6; tick(); idle();
    raddr_a = 5'd6;
    #1;
    check("sb6_set", {31'd0, busy_a}, 32'd1);
    sb_set = 1'b1; sb_addr = 5'd6; we = 1'b1; waddr = 5'd6; wdata = 32'd1;
    tick(); idle();
    check("sb6_set_wins", {31'd0, busy_a}, 32'd1);
    we = 1'b1; waddr = 5'd6; wdata = 32'd2;
    tick(); idle();
    check("sb6_cleared", {31'd0, busy_a}, 32'd0);
    sb_set = 1'b1; sb_addr = 5'd0; tick(); idle();
    raddr_b = 5'd0;
    #1;
    check("sb0_never", {31'd0, busy_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
